// File: rtl/amp_pulse_if.sv
// Host-side bundle for the pulse envelope sequencer: request/config
// inputs toward the sequencer and the ampi/ampq envelope back out.
interface amp_pulse_if;
  // start behaves as valid and !busy as ready: a request is taken on the
  // first clk edge where start=1 and busy=0; start while busy is dropped.
  // abort is a level sampled every clk and acts only during UP or FLAT.
  logic               start;
  logic               abort;
  logic signed [15:0] target_i;
  logic signed [15:0] target_q;
  logic [3:0]         ramp_log2;
  logic [15:0]        step_div;
  logic [15:0]        flat_len;
  logic signed [15:0] ampi;
  logic signed [15:0] ampq;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, target_i, target_q, ramp_log2, step_div, flat_len,
    input  ampi, ampq, busy, done
  );

  modport slave (
    input  start, abort, target_i, target_q, ramp_log2, step_div, flat_len,
    output ampi, ampq, busy, done
  );
endinterface

// File: rtl/amp_pulse_seq.sv
// RF pulse envelope generator: linear ramp up to a complex target, flat top,
// linear ramp back to zero, driving the ampi/ampq inputs of the IQ source.
module amp_pulse_seq #(
  parameter int LOG2_MAX = 12,
  parameter int FRAC     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  amp_pulse_if.slave    bus,
  output logic [1:0]    dbg_state
);

  localparam int AW = 16 + FRAC;
  localparam int KW = LOG2_MAX + 1;
  localparam logic [3:0] N_MAX = 4'(LOG2_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_FLAT = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [AW-1:0] inc_i, inc_q;
  logic signed [AW-1:0] acc_i, acc_q;
  logic [KW-1:0]        k;
  logic [KW-1:0]        k_inc;
  logic [KW-1:0]        steps;
  logic [15:0]          presc;
  logic [15:0]          step_div_q;
  logic [15:0]          flat_len_q;
  logic [15:0]          flat_cnt;
  logic                 done_q;
  logic                 tick;

  // capture-time values
  logic signed [15:0]   tgt_i_c, tgt_q_c;
  logic [3:0]           n_c;
  logic [5:0]           shamt;
  logic signed [AW-1:0] tgt_i_ext, tgt_q_ext;
  logic signed [AW-1:0] inc_i_c, inc_q_c;
  logic [KW-1:0]        steps_c;

  // -32768 has no positive mirror; clamping keeps the ramp symmetric.
  always_comb begin
    tgt_i_c   = (bus.target_i == 16'sh8000) ? 16'sh8001 : bus.target_i;
    tgt_q_c   = (bus.target_q == 16'sh8000) ? 16'sh8001 : bus.target_q;
    n_c       = (bus.ramp_log2 > N_MAX) ? N_MAX : bus.ramp_log2;
    shamt     = 6'(FRAC) - 6'(n_c);
    tgt_i_ext = AW'(tgt_i_c);
    tgt_q_ext = AW'(tgt_q_c);
    inc_i_c   = tgt_i_ext <<< shamt;
    inc_q_c   = tgt_q_ext <<< shamt;
    steps_c   = KW'(1) << n_c;
  end

  assign tick  = (presc == step_div_q);
  assign k_inc = k + KW'(1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_UP;
      end
      S_UP: begin
        if (bus.abort) begin
          state_nxt = S_DOWN;
        end else if (tick && (k_inc == steps)) begin
          state_nxt = (flat_len_q != 16'd0) ? S_FLAT : S_DOWN;
        end
      end
      S_FLAT: begin
        if (bus.abort || (flat_cnt == 16'(flat_len_q - 16'd1))) state_nxt = S_DOWN;
      end
      S_DOWN: begin
        // k can be 0 here only after an abort before the first up-tick.
        if (k == '0) begin
          state_nxt = S_IDLE;
        end else if (tick && (k == KW'(1))) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath: capture, prescaler, step counter and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_i      <= '0;
      inc_q      <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      k          <= '0;
      steps      <= '0;
      presc      <= '0;
      step_div_q <= '0;
      flat_len_q <= '0;
      flat_cnt   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == S_DOWN) && (state_nxt == S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            inc_i      <= inc_i_c;
            inc_q      <= inc_q_c;
            steps      <= steps_c;
            step_div_q <= bus.step_div;
            flat_len_q <= bus.flat_len;
            acc_i      <= '0;
            acc_q      <= '0;
            k          <= '0;
            presc      <= '0;
            flat_cnt   <= '0;
          end
        end
        S_UP: begin
          if (bus.abort) begin
            presc <= '0;
          end else if (tick) begin
            acc_i    <= acc_i + inc_i;
            acc_q    <= acc_q + inc_q;
            k        <= k_inc;
            presc    <= '0;
            flat_cnt <= '0;
          end else begin
            presc <= presc + 16'd1;
          end
        end
        S_FLAT: begin
          if (state_nxt == S_DOWN) begin
            presc    <= '0;
            flat_cnt <= '0;
          end else begin
            flat_cnt <= flat_cnt + 16'd1;
          end
        end
        S_DOWN: begin
          if (k != '0) begin
            if (tick) begin
              acc_i <= acc_i - inc_i;
              acc_q <= acc_q - inc_q;
              k     <= k - KW'(1);
              presc <= '0;
            end else begin
              presc <= presc + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // outputs; acc is always k*inc so the top slice is exact at the endpoints
  always_comb begin
    bus.ampi  = acc_i[FRAC+15:FRAC];
    bus.ampq  = acc_q[FRAC+15:FRAC];
    bus.busy  = (state != S_IDLE);
    bus.done  = done_q;
    dbg_state = state;
  end

endmodule

// File: doc/amp_pulse_seq.md
Name: amp_pulse_seq

Overview:
- Sequences the ampi/ampq amplitude inputs of the IQ tone-source multiplier stage (d_out = ampi*cos + ampq*sin).
- On a start request it generates a shaped RF pulse envelope: a linear ramp from zero to a programmed complex target, a flat top, then a linear ramp back to zero.
- Sits between the register/host interface and the source datapath.
- Its outputs connect directly to ampi/ampq.

Parameters:
- LOG2_MAX, 12, maximum ramp length exponent; ramp is 2^n steps with n in 0..LOG2_MAX.
- FRAC, 16, fractional guard bits in amplitude accumulators; must be >= LOG2_MAX.

Ports:
- clk  in  1  system clock; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse request, sampled every clk.
- abort  in  1  request early ramp-down, sampled every clk.
- target_i  in  16 signed  flat-top I amplitude.
- target_q  in  16 signed  flat-top Q amplitude.
- ramp_log2  in  4  n, ramp step-count exponent.
- step_div  in  16  clocks per ramp step minus one.
- flat_len  in  16  flat-top length in clocks; 0 = no flat top.
- ampi  out  16 signed  I amplitude to source.
- ampq  out  16 signed  Q amplitude to source.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset (async assert, sync deassert handled by clk): state IDLE; ampi=ampq=0; busy=0; done=0; all counters and accumulators 0.
- States:
  - IDLE: start=1 captures inputs and moves to UP next cycle. Capture: target=-32768 is clamped to -32767; ramp_log2 > LOG2_MAX is clamped to LOG2_MAX. Increment inc = target * 2^(FRAC-n), a signed value of (16+FRAC) bits, per channel. Prescaler and step count k cleared.
  - UP: prescaler counts 0..step_div. When prescaler = step_div: tick, acc += inc, k++, prescaler to 0. After the tick where k reaches 2^n, go to FLAT if flat_len != 0, else DOWN.
  - FLAT: count flat_len clocks, then go to DOWN with prescaler 0.
  - DOWN: same prescaler. Each tick: acc -= inc, k--. After the tick where k reaches 0, go to IDLE, pulse done for 1 cycle, busy drops in the same cycle.
- ampi/ampq are registered and equal acc[FRAC+15:FRAC]; they update on the clock after each tick.
- Arithmetic is exact: acc is always k*inc, so the top reaches exactly target and returns exactly to 0. No saturation is needed, because |acc| <= |target|.
- UP duration = 2^n*(step_div+1) clocks; DOWN duration is the same. n=0 gives a single-step jump.
- start while busy: ignored, with no effect on captured values.
- abort in UP or FLAT: go to DOWN on the next cycle with prescaler 0; ramp-down starts from the current k. abort in IDLE or DOWN: ignored.
- start and abort together in IDLE: start wins.
- Inputs other than start/abort are only sampled at capture; changes during a pulse have no effect.
- rst_n assertion mid-pulse: outputs go to 0 immediately (asynchronously), with no done pulse.
- |target_i + j*target_q| < 1 full scale is the host's responsibility and is not checked.

Test Plan:
- Basic pulse: target_i=16384, target_q=-8192, n=2, step_div=0, flat_len=3, start pulse -> ampi 4096,8192,12288,16384 on successive clocks; ampq -2048..-8192; hold for 3 clocks; then 12288,8192,4096,0; done pulse 1 clk on the cycle ampi returns to 0; busy high throughout.
- Prescale and clamp: target_i=-32768, n=0, step_div=4, flat_len=0 -> ampi=-32767 after 5 clocks, 0 after 5 more; done once.
- Abort mid-ramp: target_i=32000, n=3, step_div=1, abort after the 3rd tick -> ampi goes 4000,8000,12000, then ramps 8000,4000,0 at 2-clock spacing; done asserted.
- Ignored requests: start asserted during FLAT with different targets -> waveform unchanged, no restart. abort in IDLE -> busy stays 0.
- Async reset: rst_n low during FLAT with ampi=16384 -> ampi=ampq=0, busy=0 without waiting for a clock edge, no done. After release, a start runs a normal pulse.
- Max ramp: n=15 requested -> clamped to 12, so UP takes 4096*(step_div+1) clocks and ends at exactly target.
